// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter.
// Sends one byte with a clock-inhibit request-to-send and checks the device ACK.
//
// Ports:
//   Clk, Reset            system clock, synchronous active-high reset
//   PS2ClkIn, PS2DataIn   raw PS/2 pin levels (asynchronous)
//   Start, TxData         one-cycle transmit request and command byte
//   PS2ClkOE, PS2DataOE   1 = pull the line low, 0 = release it
//   Busy                  transfer in progress (through the Done cycle)
//   Done                  one-cycle end-of-transfer pulse
//   AckOk, Error          status, valid only while Done=1
//
// Optional feature: define PS2TX_TIMEOUT_EN to enable the watchdog that
// aborts a transfer TIMEOUT_CYCLES after clock release (sets Error).
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       PS2ClkIn,
   input  logic       PS2DataIn,
   input  logic       Start,
   input  logic [7:0] TxData,
   output logic       PS2ClkOE,
   output logic       PS2DataOE,
   output logic       Busy,
   output logic       Done,
   output logic       AckOk,
   output logic       Error
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
   localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      INHIBIT,
      SHIFT,
      WAIT_IDLE
   } state_t;

   state_t        state;
   logic          clk_s1;
   logic          clk_s2;
   logic          clk_prev;
   logic          dat_s1;
   logic          dat_s2;
   logic          fall;
   logic [IW-1:0] inh_cnt;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;
   // XOR of the data bits: the OE value for the odd-parity slot
   logic          par;
   logic          ack_r;
   logic          tmo;

`ifdef PS2TX_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] wdog;
   assign tmo = (wdog == TMO_LAST);
`else
   logic unused_tmo_cfg;
   assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
   assign tmo   = 1'b0;
   assign Error = 1'b0;
`endif

   // Synchronizers idle high so reset never fakes a falling edge
   always_ff @(posedge Clk) begin
      if (Reset) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
      end else begin
         clk_s1   <= PS2ClkIn;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= PS2DataIn;
         dat_s2   <= dat_s1;
      end
   end

   assign fall = clk_prev & ~clk_s2;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= IDLE;
         PS2ClkOE  <= 1'b0;
         PS2DataOE <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         AckOk     <= 1'b0;
         inh_cnt   <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         par       <= 1'b0;
         ack_r     <= 1'b0;
`ifdef PS2TX_TIMEOUT_EN
         Error     <= 1'b0;
         wdog      <= '0;
`endif
      end else begin
         Done  <= 1'b0;
         AckOk <= 1'b0;
`ifdef PS2TX_TIMEOUT_EN
         Error <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               // Busy is still high in the Done cycle, blocking Start
               Busy      <= 1'b0;
               PS2ClkOE  <= 1'b0;
               PS2DataOE <= 1'b0;
               if (Start && !Busy) begin
                  state    <= INHIBIT;
                  Busy     <= 1'b1;
                  PS2ClkOE <= 1'b1;
                  shreg    <= TxData;
                  par      <= ^TxData;
                  inh_cnt  <= '0;
                  bit_cnt  <= '0;
                  ack_r    <= 1'b0;
               end
            end
            INHIBIT: begin
               inh_cnt <= inh_cnt + 1'b1;
               if (inh_cnt == INH_PRE) begin
                  PS2DataOE <= 1'b1;
               end
               if (inh_cnt == INH_LAST) begin
                  state     <= SHIFT;
                  PS2ClkOE  <= 1'b0;
                  PS2DataOE <= 1'b1;
`ifdef PS2TX_TIMEOUT_EN
                  wdog      <= '0;
`endif
               end
            end
            SHIFT: begin
`ifdef PS2TX_TIMEOUT_EN
               wdog <= wdog + 1'b1;
`endif
               if (fall) begin
                  bit_cnt <= bit_cnt + 1'b1;
                  unique case (1'b1)
                     (bit_cnt < 4'd8): begin
                        PS2DataOE <= ~shreg[0];
                        shreg     <= shreg >> 1;
                     end
                     (bit_cnt == 4'd8): PS2DataOE <= par;
                     (bit_cnt == 4'd9): PS2DataOE <= 1'b0;
                     default: begin
                        ack_r     <= ~dat_s2;
                        PS2DataOE <= 1'b0;
                        state     <= WAIT_IDLE;
                     end
                  endcase
               end
               // An ACK sampled on the expiry cycle still wins
               if (tmo && !(fall && bit_cnt == 4'd10)) begin
                  state     <= IDLE;
                  PS2ClkOE  <= 1'b0;
                  PS2DataOE <= 1'b0;
                  Done      <= 1'b1;
`ifdef PS2TX_TIMEOUT_EN
                  Error     <= 1'b1;
`endif
               end
            end
            WAIT_IDLE: begin
               PS2ClkOE  <= 1'b0;
               PS2DataOE <= 1'b0;
               if (clk_s2 && dat_s2) begin
                  state <= IDLE;
                  Done  <= 1'b1;
                  AckOk <= ack_r;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized scoreboard bench for ps2_host_tx.
// Device model clocks frames; a monitor checks every Done pulse.
module tb_ps2_host_tx;

   localparam int INH = 8;
   localparam int TMO = 500;
   localparam int HALF = 20;

   logic       Clk;
   logic       Reset;
   logic       Start;
   logic [7:0] TxData;
   logic       PS2ClkOE;
   logic       PS2DataOE;
   logic       Busy;
   logic       Done;
   logic       AckOk;
   logic       Error;
   logic       dev_clk_low;
   logic       dev_data_low;
   logic       ps2c;
   logic       ps2d;

   // Open-drain wired lines
   assign ps2c = ~(PS2ClkOE | dev_clk_low);
   assign ps2d = ~(PS2DataOE | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .Clk(Clk),
      .Reset(Reset),
      .PS2ClkIn(ps2c),
      .PS2DataIn(ps2d),
      .Start(Start),
      .TxData(TxData),
      .PS2ClkOE(PS2ClkOE),
      .PS2DataOE(PS2DataOE),
      .Busy(Busy),
      .Done(Done),
      .AckOk(AckOk),
      .Error(Error)
   );

   typedef struct {
      logic [10:0] frame;
      logic        chk_frame;
      logic        ack;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   int          cmp_n = 0;
   int          bad_n = 0;
   int          done_cnt = 0;
   int          cyc = 0;
   int          rel_cyc = 0;
   logic [10:0] obs_frame = '0;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   initial begin
      repeat (90000) @(posedge Clk);
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         bad_n++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Frame as the device sees it: start, D0..D7, odd parity, stop
   function automatic logic [10:0] frame_of(input logic [7:0] b);
      return {1'b1, ~(^b), b, 1'b0};
   endfunction

   // Monitor: compares every Done pulse with the scoreboard head
   initial begin : monitor
      exp_t e;
      bit   after;
      after = 0;
      forever begin
         @(negedge Clk);
         if (Done) begin
            chk("done_busy", Busy, 1);
            chk("done_clkoe", PS2ClkOE, 0);
            chk("done_dataoe", PS2DataOE, 0);
            if (exp_q.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("ackok", AckOk, e.ack);
               chk("error", Error, e.err);
               if (e.chk_frame) chk("frame", obs_frame, e.frame);
               if (e.err) chk("tmo_delay", cyc - rel_cyc, TMO);
            end
            done_cnt++;
            after = 1;
         end else begin
            if (after) begin
               chk("busy_after_done", Busy, 0);
               chk("oe_after_done", {PS2ClkOE, PS2DataOE}, 0);
            end
            after = 0;
            chk("status_idle", {AckOk, Error}, 0);
         end
      end
   end

   // Host request plus device model clocking nclk falling edges
   task automatic send(input logic [7:0] b, input bit ack,
                       input int nclk, input bit poke,
                       input bit expect_done);
      int          t;
      int          dl;
      int          d0;
      logic [10:0] f;
      exp_t        e;
      f = '0;
      e.frame = frame_of(b);
      e.chk_frame = (nclk == 11);
      e.ack = ack && (nclk == 11);
      e.err = (nclk < 11);
      if (expect_done) exp_q.push_back(e);
      d0 = done_cnt;
      Start = 1'b1;
      TxData = b;
      @(negedge Clk);
      Start = 1'b0;
      TxData = 8'($urandom);
      chk("busy_after_start", Busy, 1);
      chk("clkoe_after_start", PS2ClkOE, 1);
      t = 1;
      dl = int'(PS2DataOE);
      while (PS2ClkOE && t < 4 * INH) begin
         @(negedge Clk);
         if (PS2ClkOE) begin
            t++;
            dl += int'(PS2DataOE);
         end
      end
      rel_cyc = cyc;
      chk("inhibit_len", t, INH);
      chk("inhibit_data_cycles", dl, 1);
      chk("start_bit_oe", PS2DataOE, 1);
      repeat (10) @(negedge Clk);
      f[0] = ps2d;
      for (int k = 1; k <= nclk; k++) begin
         if (k == 11 && ack) begin
            dev_data_low = 1'b1;
            repeat (2) @(negedge Clk);
         end
         dev_clk_low = 1'b1;
         repeat (HALF) @(negedge Clk);
         if (poke && k == 5) begin
            Start = 1'b1;
            TxData = 8'h00;
            @(negedge Clk);
            Start = 1'b0;
         end
         if (k <= 10) f[k] = ps2d;
         if (k == 10) obs_frame = f;
         dev_clk_low = 1'b0;
         repeat (HALF) @(negedge Clk);
      end
      dev_data_low = 1'b0;
      if (expect_done) begin
         for (t = 0; t < 2 * TMO && done_cnt == d0; t++)
            @(negedge Clk);
         chk("done_seen", done_cnt - d0, 1);
         repeat (3) @(negedge Clk);
      end
   endtask

   initial begin : stim
      logic [7:0] b;
      int         d0;
      Reset = 1'b1;
      Start = 1'b0;
      TxData = 8'h00;
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
      repeat (3) @(negedge Clk);
      chk("reset_outs",
          {PS2ClkOE, PS2DataOE, Busy, Done, AckOk, Error}, 0);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);

      // Start coincident with Reset is dropped
      Reset = 1'b1;
      Start = 1'b1;
      TxData = 8'h5A;
      @(negedge Clk);
      Reset = 1'b0;
      Start = 1'b0;
      @(negedge Clk);
      chk("start_with_reset", {Busy, PS2ClkOE}, 0);

      // Reset held 3 cycles in the middle of INHIBIT
      Start = 1'b1;
      TxData = 8'h33;
      @(negedge Clk);
      Start = 1'b0;
      repeat (3) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);
      chk("reset_mid_inhibit",
          {PS2ClkOE, PS2DataOE, Busy, Done, AckOk, Error}, 0);
      repeat (2) @(negedge Clk);
      Reset = 1'b0;
      repeat (2) @(negedge Clk);

      send(8'hA5, 1, 11, 0, 1);
      send(8'hED, 1, 11, 0, 1);
      send(8'hF4, 0, 11, 0, 1);
      send(8'hC3, 1, 11, 1, 1);
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         send(b, 1'($urandom_range(0, 1)), 11, 0, 1);
      end

`ifdef PS2TX_TIMEOUT_EN
      send(8'hFF, 0, 4, 0, 1);
`else
      // No watchdog: stalled device leaves the host waiting
      d0 = done_cnt;
      send(8'hFF, 0, 4, 0, 0);
      repeat (TMO + 200) @(negedge Clk);
      chk("stall_busy", Busy, 1);
      chk("stall_no_done", done_cnt - d0, 0);
      chk("stall_error", Error, 0);
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      chk("stall_reset", {Busy, PS2ClkOE, PS2DataOE}, 0);
      @(negedge Clk);
      send(8'h81, 1, 11, 0, 1);
`endif

      chk("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmp_n, bad_n);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xED (set LEDs) or 0xFF (reset), from the host to the keyboard over the shared open-drain clock and data lines. It performs the clock-inhibit request-to-send sequence, shifts out the data/parity/stop frame on device-generated clock edges, and checks the device acknowledge bit. It sits beside the keyboard receive path and shares the PS/2 pins through tri-state pads; the receive path must ignore the lines while Busy=1.

## Interface
- INHIBIT_CYCLES, 5000, Clk cycles the host holds PS/2 clock low before releasing it (100 µs at 50 MHz); minimum 2.
- TIMEOUT_CYCLES, 1000000, Clk cycles allowed from clock release to acknowledge; used only with the timeout feature.
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- PS2ClkIn  input  1  raw PS/2 clock pin level (asynchronous).
- PS2DataIn  input  1  raw PS/2 data pin level (asynchronous).
- Start  input  1  one-cycle request to transmit TxData; ignored while Busy=1.
- TxData  input  8  command byte, captured on the cycle Start is accepted.
- PS2ClkOE  output  1  1 = pull PS/2 clock low; 0 = release.
- PS2DataOE  output  1  1 = pull PS/2 data low; 0 = release.
- Busy  output  1  high from the cycle after Start is accepted until the cycle Done pulses, inclusive.
- Done  output  1  one-cycle pulse at the end of a transfer.
- AckOk  output  1  valid while Done=1: the device drove the ACK bit low.
- Error  output  1  valid while Done=1: the transfer timed out.

## Operation
- Both pins pass through a 2-FF synchronizer. A falling edge (FallEdge) is detected when the previous synchronized clock is 1 and the current one is 0.
- Frame: start bit 0, D0..D7 LSB first, odd parity (XOR of the 8 bits, inverted), stop bit 1, then the device ACK.
- States:
  - IDLE: both OEs=0. On Start, load the shift register and parity, clear the counters, and go to INHIBIT.
  - INHIBIT: PS2ClkOE=1. PS2DataOE=1 during the last cycle only. After INHIBIT_CYCLES cycles, go to REQ.
  - REQ/SHIFT: PS2ClkOE=0 and PS2DataOE=1 (start bit). The bit counter runs 0..10 and advances only on FallEdge:
    - edges 1–8 drive PS2DataOE = ~D(edge-1);
    - edge 9 drives ~parity;
    - edge 10 sets PS2DataOE=0 (stop bit);
    - edge 11 samples synchronized data, AckOk_reg = ~data, and the FSM moves to WAIT_IDLE.
  - WAIT_IDLE: both OEs=0. When synchronized clock=1 and data=1, pulse Done and return to IDLE.
- Start is ignored in every state except IDLE. Start in the same cycle as Reset is ignored.
- Reset mid-transfer: the next cycle has all outputs at reset values and the lines released. No Done pulse is produced.

## Timing
- Reset values: PS2ClkOE=0, PS2DataOE=0, Busy=0, Done=0, AckOk=0, Error=0, state IDLE, counters 0.
- Start at edge N: Busy=1 and PS2ClkOE=1 from cycle N+1. Clock release happens at cycle N+1+INHIBIT_CYCLES.
- A pin falling edge updates PS2DataOE 3 Clk cycles later (2 sync stages + edge register). This is well inside the device's half-period of 30 µs or more.
- AckOk and Error are held stable only while Done=1. They are 0 at all other times.
- Back-to-back transfers: Start accepted the cycle after Done.

## Configuration
- PS2TX_TIMEOUT_EN defined:
  - A watchdog counts cycles from leaving INHIBIT until the sampling edge 11.
  - When the count reaches TIMEOUT_CYCLES, both OEs are released, Done=1, Error=1, AckOk=0, and the FSM returns to IDLE with no WAIT_IDLE phase.
  - Reaching the count exactly on the cycle edge 11 is sampled counts as success.
- Not defined:
  - No watchdog; the FSM waits indefinitely for device clocks.
  - Error is constant 0; TIMEOUT_CYCLES is unused.

## Test plan
- Reset: hold Reset 3 cycles mid-INHIBIT -> all outputs 0 the next cycle; a later Start runs a full normal transfer.
- Send 0xED (INHIBIT_CYCLES=8), device model clocking at a 40-cycle period -> data seen at the device's rising edges: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1; device ACK low -> Done with AckOk=1 and Error=0; Busy drops with Done.
- Send 0xF4 -> device samples 0, 0,0,1,0,1,1,1,1, parity 0, stop 1. Device leaves data high at the ACK edge -> Done with AckOk=0.
- Start pulsed again during SHIFT with TxData=0x00 -> ignored; the byte transmitted remains the original.
- With PS2TX_TIMEOUT_EN, TIMEOUT_CYCLES=500: device generates only 4 clocks -> Done and Error=1 exactly 500 cycles after clock release, both OEs=0, Busy=0 the next cycle.
- Without the macro, same stimulus -> Busy stays 1 indefinitely and Error never asserts. Reset then recovers to IDLE.
